quad_dir_decoder: RTL and testbench
===================================

// Module: quad_dir_decoder
// PURPOSE
//   Upstream front end for the 2-bit binary up/down counter. Decodes a quadrature
//   encoder (Phase_A/Phase_B) into a direction level, a one-cycle step pulse and a
//   wrapping position count.
//   Dir feeds the counter's Data_In (1 = count up, 0 = count down).
//   Step/Position/Error serve enable-gated consumers and diagnostics.
// PARAMETERS
//   SYNC_STAGES  2  synchronizer flops per phase input, legal 2..4
//   FILTER_LEN   3  consecutive equal synchronized samples needed to accept a new {A,B}, 1..15
//   POS_W        8  width of Position, legal 2..16
// PORTS
//   Clock      in   1      rising-edge clock
//   Reset      in   1      asynchronous, active-low
//   Phase_A    in   1      encoder channel A, asynchronous to Clock
//   Phase_B    in   1      encoder channel B, asynchronous to Clock
//   Clear_Err  in   1      synchronous clear of Error, level
//   Dir        out  1      last valid direction: 1 = up/forward, 0 = down/reverse
//   Step       out  1      one-cycle pulse per valid quadrature transition
//   Position   out  POS_W  signed-agnostic step count, wraps modulo 2^POS_W
//   Locked     out  1      1 once the first filtered phase value is adopted
//   Error      out  1      sticky: illegal (double-bit) phase transition seen
// BEHAVIOUR
//   Reset (async, Reset=0): sync chain=0, filter count=0, FSM=INIT, Dir=1, Step=0,
//     Position=0, Locked=0, Error=0; applies immediately, also mid-operation.
//   Sync: {A,B} passes SYNC_STAGES flops; the filter sees only the final stage.
//   Filter: count clears on any change of the synchronized value. A value is
//     "adopted" on the edge where it has been sampled FILTER_LEN consecutive times.
//     Pulses shorter than FILTER_LEN clocks are discarded.
//     In INIT, adoption occurs even if the value equals the reset value.
//   Latency: Step/Dir/Position update on edge SYNC_STAGES+FILTER_LEN after the pin
//     change, counting the first sampling edge as 1 (defaults: edge 5).
//   FSM, one-hot: INIT, S00, S01, S11, S10 (state = last adopted {A,B}).
//     INIT + adopt v     -> S(v), Locked<=1; no Step, no Error, Position held.
//     Forward Gray (00->01->11->10->00) -> Step=1, Dir<=1, Position+1.
//     Reverse Gray (00->10->11->01->00) -> Step=1, Dir<=0, Position-1.
//     Same value         -> no change.
//     Double-bit change (00<->11, 01<->10) -> Error<=1, Step=0; Dir and Position
//       held; state moves to the new value (resync).
//   Step: high for exactly one cycle per valid transition, never on two adjacent
//     cycles when FILTER_LEN>=2.
//   Position: wraps 2^POS_W-1 -> 0 up and 0 -> 2^POS_W-1 down.
//   Error: set by an illegal transition, cleared by Clear_Err=1 at a clock edge.
//     Set wins when both occur on the same edge.
//   All outputs are registered; no combinational path from inputs to outputs.
// TESTING (defaults unless stated)
//   1 Hold A/B=00, release Reset -> Locked=1 at edge 5; Step never 1;
//     Position=0; Error=0; Dir=1.
//   2 After lock at 00, drive 01,11,10,00 each held 10 clk -> four 1-clk Step
//     pulses, Dir=1, Position 0->4.
//   3 Lock at 00, drive 10 -> Step once, Dir=0, Position=255 (wrap); then 11
//     -> Position=254.
//   4 Lock at 00, pulse A=1 for 2 clk (<FILTER_LEN) -> no Step, Position/Dir
//     unchanged; 3 clk pulse -> Step up then Step down.
//   5 Lock at 00, drive 11 -> Error=1, Step=0, Position held; then 10 -> Step,
//     Position+1. Clear_Err on same edge as another illegal step -> Error stays 1.
//   6 Reset low mid-sequence at Position=3 -> Position=0, Locked=0, Dir=1
//     with no clock edge; relock per scenario 1.

Source files
------------

// File: rtl/quad_dir_decoder.sv
// quad_dir_decoder
//   Quadrature encoder front end. Synchronizes Phase_A/Phase_B, debounces the
//   pair with a consecutive-sample filter, and tracks the last adopted Gray
//   value in a one-hot FSM. It produces a direction level (Dir), a one-cycle
//   Step pulse per legal transition, a wrapping Position count, a Locked flag
//   and a sticky Error flag for illegal double-bit jumps.
//   All outputs come straight from flops.

module quad_dir_decoder #(
  parameter int SYNC_STAGES = 2,   // 2..4 flops per phase input
  parameter int FILTER_LEN  = 3,   // 1..15 equal samples to accept a value
  parameter int POS_W       = 8    // 2..16 bit position counter
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Phase_A,
  input  logic             Phase_B,
  input  logic             Clear_Err,
  output logic             Dir,
  output logic             Step,
  output logic [POS_W-1:0] Position,
  output logic             Locked,
  output logic             Error
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [3:0] FLEN = 4'(FILTER_LEN);

  // One-hot state encoding; each S state names the last adopted {A,B}.
  localparam logic [4:0] ST_INIT = 5'b00001;
  localparam logic [4:0] ST_S00  = 5'b00010;
  localparam logic [4:0] ST_S01  = 5'b00100;
  localparam logic [4:0] ST_S11  = 5'b01000;
  localparam logic [4:0] ST_S10  = 5'b10000;

  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  // Phase value -> one-hot state holding that value.
  function automatic logic [4:0] state_of(input logic [1:0] v);
    logic [4:0] s;
    case (v)
      2'b00:   s = ST_S00;
      2'b01:   s = ST_S01;
      2'b11:   s = ST_S11;
      default: s = ST_S10;
    endcase
    return s;
  endfunction

  // Position of a phase value along the forward Gray cycle 00,01,11,10.
  // The modulo-4 difference of two indices classifies a transition:
  // 1 = forward, 3 = reverse, 2 = illegal double-bit jump, 0 = no change.
  function automatic logic [1:0] gray_idx(input logic [1:0] v);
    logic [1:0] i;
    case (v)
      2'b00:   i = 2'd0;
      2'b01:   i = 2'd1;
      2'b11:   i = 2'd2;
      default: i = 2'd3;
    endcase
    return i;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizer chain
  //   valid_reg travels alongside the data so that the filter ignores the
  //   reset contents of the chain and only counts genuinely sampled pin values.
  // ---------------------------------------------------------------------------
  logic [1:0]             sync_reg [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] valid_reg;

  logic [1:0] smp;
  logic       smp_valid;

  assign smp       = sync_reg[SYNC_STAGES-1];
  assign smp_valid = valid_reg[SYNC_STAGES-1];

  // Shift the raw phase pair through SYNC_STAGES flops.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= 2'b00;
      end
      valid_reg <= '0;
    end else begin
      sync_reg[0]  <= {Phase_A, Phase_B};
      valid_reg[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i]  <= sync_reg[i-1];
        valid_reg[i] <= valid_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Consecutive-sample filter
  //   cand_reg is the value currently being timed, cnt_reg the number of
  //   consecutive samples of it seen so far (saturating at FILTER_LEN).
  //   adopt fires once, on the edge that delivers the FILTER_LEN-th sample.
  // ---------------------------------------------------------------------------
  logic [1:0] cand_reg;
  logic [3:0] cnt_reg;
  logic       adopt;

  // Decide whether the sample arriving on this edge completes a filter run.
  always_comb begin
    adopt = 1'b0;
    if (smp_valid) begin
      if (smp != cand_reg) begin
        adopt = (FLEN == 4'd1);
      end else begin
        adopt = (cnt_reg == FLEN - 4'd1);
      end
    end
  end

  // Track the candidate value and how long it has been stable.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cand_reg <= 2'b00;
      cnt_reg  <= 4'd0;
    end else if (smp_valid) begin
      if (smp != cand_reg) begin
        cand_reg <= smp;
        cnt_reg  <= 4'd1;
      end else if (cnt_reg != FLEN) begin
        cnt_reg  <= cnt_reg + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder FSM and registered outputs
  // ---------------------------------------------------------------------------
  logic [4:0]       state_reg,  state_next;
  logic             dir_reg,    dir_next;
  logic             step_reg,   step_next;
  logic [POS_W-1:0] pos_reg,    pos_next;
  logic             locked_reg, locked_next;
  logic             error_reg,  error_next;

  logic [1:0] cur_val;
  logic       in_init;
  logic [1:0] move;

  // Decode the current state into its phase value; corrupt codes act as INIT.
  always_comb begin
    cur_val = 2'b00;
    in_init = 1'b0;
    case (state_reg)
      ST_S00:  cur_val = 2'b00;
      ST_S01:  cur_val = 2'b01;
      ST_S11:  cur_val = 2'b11;
      ST_S10:  cur_val = 2'b10;
      default: in_init = 1'b1;
    endcase
  end

  assign move = gray_idx(smp) - gray_idx(cur_val);

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= ST_INIT;
      dir_reg    <= 1'b1;
      step_reg   <= 1'b0;
      pos_reg    <= '0;
      locked_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dir_reg    <= dir_next;
      step_reg   <= step_next;
      pos_reg    <= pos_next;
      locked_reg <= locked_next;
      error_reg  <= error_next;
    end
  end

  // Next state: every adopted value becomes the new state, including after an
  // illegal jump, so the decoder resynchronizes to the encoder immediately.
  always_comb begin
    state_next = state_reg;
    if (adopt) begin
      state_next = state_of(smp);
    end
  end

  // Output updates driven by the classified transition. Error clear is applied
  // first so that a simultaneous illegal transition overrides it.
  always_comb begin
    dir_next    = dir_reg;
    step_next   = 1'b0;
    pos_next    = pos_reg;
    locked_next = locked_reg;
    error_next  = Clear_Err ? 1'b0 : error_reg;
    if (adopt) begin
      if (in_init) begin
        locked_next = 1'b1;
      end else begin
        case (move)
          2'd1: begin
            step_next = 1'b1;
            dir_next  = 1'b1;
            pos_next  = pos_reg + POS_ONE;
          end
          2'd3: begin
            step_next = 1'b1;
            dir_next  = 1'b0;
            pos_next  = pos_reg - POS_ONE;
          end
          2'd2: begin
            error_next = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign Dir      = dir_reg;
  assign Step     = step_reg;
  assign Position = pos_reg;
  assign Locked   = locked_reg;
  assign Error    = error_reg;

endmodule

// File: tb/tb_quad_dir_decoder.sv
// tb_quad_dir_decoder
//   Directed scenarios for quad_dir_decoder at default parameters. Inputs are
//   driven and outputs sampled on the falling clock edge; "edge k" below is the
//   k-th rising edge after the pins change.

module tb_quad_dir_decoder;

  logic       Clock;
  logic       Reset;
  logic       Phase_A;
  logic       Phase_B;
  logic       Clear_Err;
  logic       Dir;
  logic       Step;
  logic [7:0] Position;
  logic       Locked;
  logic       Error;

  int n_checks;
  int n_fail;

  quad_dir_decoder dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Phase_A   (Phase_A),
    .Phase_B   (Phase_B),
    .Clear_Err (Clear_Err),
    .Dir       (Dir),
    .Step      (Step),
    .Position  (Position),
    .Locked    (Locked),
    .Error     (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Hard stop in case the sequence never completes.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish before 2 ms");
    $fatal(1, "timeout");
  end

  // Reset, hold 00 and wait until the decoder has locked at S00.
  task automatic do_reset;
    Reset     = 1'b0;
    Phase_A   = 1'b0;
    Phase_B   = 1'b0;
    Clear_Err = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (8) @(negedge Clock);
  endtask

  // Drive a phase pair for n cycles; report Step pulses, first pulse edge and
  // count of back-to-back Step cycles.
  task automatic apply(input logic [1:0] v, input int n,
                       output int steps, output int first_edge, output int adj);
    logic prev;
    Phase_A    = v[1];
    Phase_B    = v[0];
    steps      = 0;
    first_edge = -1;
    adj        = 0;
    prev       = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge Clock);
      if (Step === 1'b1) begin
        steps++;
        if (first_edge < 0) first_edge = k;
        if (prev) adj++;
      end
      prev = (Step === 1'b1);
    end
    $display("drive AB=%b for %0d clk: steps=%0d first=%0d Dir=%b Pos=%0d Err=%b",
             v, n, steps, first_edge, Dir, Position, Error);
  endtask

  // Scenario 1: reset values, then lock at 00 on edge 5 with no Step.
  task automatic test_reset;
    Reset = 1'b0; Phase_A = 1'b0; Phase_B = 1'b0; Clear_Err = 1'b0;
    repeat (3) @(negedge Clock);
    n_checks++;
    if ({Dir, Step, Position, Locked, Error} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: Dir/Step/Pos/Locked/Err=%b/%b/%0d/%b/%b required 1/0/0/0/0",
               Dir, Step, Position, Locked, Error);
    end
    Reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      n_checks++;
      if (Locked !== (k >= 5) || Step !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_edge_%0d: Locked=%b Step=%b required Locked=%b Step=0",
                 k, Locked, Step, (k >= 5));
      end
    end
    n_checks++;
    if ({Dir, Position, Error} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_lock: Dir/Pos/Err=%b/%0d/%b required 1/0/0", Dir, Position, Error);
    end
    $display("test_reset done: Locked=%b Pos=%0d", Locked, Position);
  endtask

  // Scenario 2: full forward Gray cycle, one Step each at edge 5.
  task automatic test_forward;
    logic [1:0] seq [4];
    int steps, first, adj;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(seq[i], 10, steps, first, adj);
      n_checks++;
      if (steps !== 1 || first !== 5 || adj !== 0) begin
        n_fail++;
        $display("FAIL fwd_step_%0d: steps=%0d first=%0d adj=%0d required 1/5/0",
                 i, steps, first, adj);
      end
      n_checks++;
      if (Dir !== 1'b1 || Position !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL fwd_pos_%0d: Dir=%b Pos=%0d required Dir=1 Pos=%0d",
                 i, Dir, Position, i + 1);
      end
    end
  endtask

  // Scenario 3: reverse from 00 wraps to 255, then 254.
  task automatic test_reverse;
    int steps, first, adj;
    do_reset();
    apply(2'b10, 10, steps, first, adj);
    n_checks++;
    if (steps !== 1 || Dir !== 1'b0 || Position !== 8'd255) begin
      n_fail++;
      $display("FAIL rev_wrap: steps=%0d Dir=%b Pos=%0d required 1/0/255", steps, Dir, Position);
    end
    apply(2'b11, 10, steps, first, adj);
    n_checks++;
    if (steps !== 1 || Dir !== 1'b0 || Position !== 8'd254) begin
      n_fail++;
      $display("FAIL rev_second: steps=%0d Dir=%b Pos=%0d required 1/0/254", steps, Dir, Position);
    end
  endtask

  // Scenario 4: 2-clk glitch is filtered, 3-clk pulse gives up then down.
  task automatic test_glitch;
    int steps, first, adj;
    int steps2, first2, adj2;
    do_reset();
    apply(2'b01, 2, steps, first, adj);
    apply(2'b00, 10, steps2, first2, adj2);
    n_checks++;
    if (steps + steps2 !== 0 || Position !== 8'd0 || Dir !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_2clk: steps=%0d Pos=%0d Dir=%b required 0/0/1",
               steps + steps2, Position, Dir);
    end
    apply(2'b01, 3, steps, first, adj);
    apply(2'b00, 10, steps2, first2, adj2);
    n_checks++;
    // Up step lands on edge 5 (2nd clk of the 00 phase), down step on edge 8.
    if (steps !== 0 || steps2 !== 2 || first2 !== 2 || adj2 !== 0) begin
      n_fail++;
      $display("FAIL pulse_3clk_steps: steps=%0d/%0d first=%0d adj=%0d required 0/2 first=2 adj=0",
               steps, steps2, first2, adj2);
    end
    n_checks++;
    if (Position !== 8'd0 || Dir !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_3clk_state: Pos=%0d Dir=%b required Pos=0 Dir=0", Position, Dir);
    end
  endtask

  // Scenario 5: illegal jump, resync, clear, and set-wins-over-clear.
  task automatic test_error;
    int steps, first, adj;
    do_reset();
    apply(2'b11, 10, steps, first, adj);
    n_checks++;
    if (steps !== 0 || Error !== 1'b1 || Position !== 8'd0 || Dir !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_jump: steps=%0d Err=%b Pos=%0d Dir=%b required 0/1/0/1",
               steps, Error, Position, Dir);
    end
    apply(2'b10, 10, steps, first, adj);
    n_checks++;
    if (steps !== 1 || Position !== 8'd1 || Dir !== 1'b1 || Error !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_step: steps=%0d Pos=%0d Dir=%b Err=%b required 1/1/1/1",
               steps, Position, Dir, Error);
    end
    Clear_Err = 1'b1;
    @(negedge Clock);
    Clear_Err = 1'b0;
    n_checks++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_err: Err=%b required 0", Error);
    end
    // 10 -> 01 is illegal; it is adopted on edge 5, where Clear_Err is also high.
    apply(2'b01, 4, steps, first, adj);
    n_checks++;
    if (Error !== 1'b0 || steps !== 0) begin
      n_fail++;
      $display("FAIL pre_collision: Err=%b steps=%0d required 0/0", Error, steps);
    end
    Clear_Err = 1'b1;
    @(negedge Clock);
    Clear_Err = 1'b0;
    n_checks++;
    if (Error !== 1'b1 || Step !== 1'b0 || Position !== 8'd1) begin
      n_fail++;
      $display("FAIL set_wins: Err=%b Step=%b Pos=%0d required 1/0/1", Error, Step, Position);
    end
    $display("test_error done: Err=%b Pos=%0d", Error, Position);
  endtask

  // Scenario 6: asynchronous reset mid-sequence, then relock.
  task automatic test_async_reset;
    logic [1:0] seq [3];
    int steps, first, adj;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
    do_reset();
    for (int i = 0; i < 3; i++) apply(seq[i], 10, steps, first, adj);
    n_checks++;
    if (Position !== 8'd3) begin
      n_fail++;
      $display("FAIL pre_reset_pos: Pos=%0d required 3", Position);
    end
    // Clock is low here; the next rising edge is 5 time units away.
    #2;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (Position !== 8'd0 || Locked !== 1'b0 || Dir !== 1'b1 || Step !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: Pos=%0d Locked=%b Dir=%b Step=%b required 0/0/1/0",
               Position, Locked, Dir, Step);
    end
    @(negedge Clock);
    Phase_A = 1'b0;
    Phase_B = 1'b0;
    Reset   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      n_checks++;
      if (Locked !== (k >= 5) || Step !== 1'b0 || Position !== 8'd0) begin
        n_fail++;
        $display("FAIL relock_edge_%0d: Locked=%b Step=%b Pos=%0d required Locked=%b Step=0 Pos=0",
                 k, Locked, Step, Position, (k >= 5));
      end
    end
    $display("test_async_reset done: Locked=%b Pos=%0d", Locked, Position);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Reset     = 1'b0;
    Phase_A   = 1'b0;
    Phase_B   = 1'b0;
    Clear_Err = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_error();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
